// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed 7-segment driver for the packed BCD result of the binary-to-BCD converter.
// Shadow-latches the value on load, scans digits every SCAN_DIV cycles, optionally blanks leading zeros.
module bcd_7seg_scan #(
  parameter int SCAN_DIV    = 4,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] bcd,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        err
);

  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;

  logic [11:0]   shadow_q, shadow_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          err_q, err_d;

  logic [3:0]    nib;
  logic [2:0]    an_sel;
  logic          blank;
  logic [6:0]    seg_hi;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    shadow_d  = shadow_q;
    err_d     = err_q;
    div_cnt_d = div_cnt_q + CW'(1);
    idx_d     = idx_q;

    if (load) begin
      shadow_d = bcd;
      err_d    = (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    end

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // An invalid nibble is non-zero, so the equality tests keep it lit.
    case (idx_q)
      2'd0: begin
        nib    = shadow_q[3:0];
        an_sel = 3'b110;
        blank  = 1'b0;
      end
      2'd1: begin
        nib    = shadow_q[7:4];
        an_sel = 3'b101;
        blank  = blank_lz && (shadow_q[11:4] == 8'h00);
      end
      default: begin
        nib    = shadow_q[11:8];
        an_sel = 3'b011;
        blank  = blank_lz && (shadow_q[11:8] == 4'h0);
      end
    endcase

    seg_hi = seg_of(nib);
    if (blank) begin
      an_d  = 3'b111;
      seg_d = SEG_OFF;
    end else begin
      an_d  = an_sel;
      seg_d = SEG_ACT_LOW ? ~seg_hi : seg_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_OFF;
      an_q      <= 3'b111;
      err_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      err_q     <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle (an, seg, err); a monitor pops and compares.
// A second instance with SEG_ACT_LOW=1 shares the inputs and is checked against inverted segments.
module tb_bcd_7seg_scan;

  typedef struct packed {
    logic       chk;
    logic [2:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [11:0] bcd = 12'h000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg, seg_l;
  logic [2:0]  an, an_l;
  logic        err, err_l;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bcd_7seg_scan #(.SCAN_DIV(2), .SEG_ACT_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd(bcd), .blank_lz(blank_lz),
    .seg(seg), .an(an), .err(err)
  );

  bcd_7seg_scan #(.SCAN_DIV(2), .SEG_ACT_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .load(load), .bcd(bcd), .blank_lz(blank_lz),
    .seg(seg_l), .an(an_l), .err(err_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a new output every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("an",    {4'b0, an},    {4'b0, e.an});
          check("seg",   seg,           e.seg);
          check("err",   {6'b0, err},   {6'b0, e.err});
          check("seg_l", seg_l,         ~e.seg);
          check("an_l",  {4'b0, an_l},  {4'b0, e.an});
        end
      end
    end
  end

  task automatic cyc(input logic ld, input logic [11:0] b, input logic blz,
                     input logic [2:0] ea, input logic [6:0] es, input logic ee);
    exp_t e;
    load     = ld;
    bcd      = b;
    blank_lz = blz;
    e.chk = 1'b1;
    e.an  = ea;
    e.seg = es;
    e.err = ee;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_now(input logic ld, input logic [11:0] b);
    rst  = 1'b1;
    load = ld;
    bcd  = b;
    #1;
    check("rst_an",    {4'b0, an},  7'h07);
    check("rst_seg",   seg,         7'h00);
    check("rst_err",   {6'b0, err}, 7'h00);
    check("rst_seg_l", seg_l,       7'h7F);
  endtask

  // Reset, hold, then release with the load presented for the first edge.
  task automatic start(input logic [11:0] b, input logic blz, input logic e_err);
    reset_now(1'b0, b);
    repeat (2) cyc(1'b0, b, blz, 3'b111, 7'h00, 1'b0);
    rst = 1'b0;
    cyc(1'b1, b, blz, 3'b110, 7'h3F, e_err);
  endtask

  // Second ones cycle, then reps x (tens, tens, hundreds, hundreds, ones, ones).
  task automatic scan(input logic blz,
                      input logic [2:0] a0, input logic [6:0] s0,
                      input logic [2:0] a1, input logic [6:0] s1,
                      input logic [2:0] a2, input logic [6:0] s2,
                      input logic e_err, input int reps);
    cyc(1'b0, 12'h000, blz, a0, s0, e_err);
    for (int r = 0; r < reps; r++) begin
      repeat (2) cyc(1'b0, 12'h000, blz, a1, s1, e_err);
      repeat (2) cyc(1'b0, 12'h000, blz, a2, s2, e_err);
      repeat (2) cyc(1'b0, 12'h000, blz, a0, s0, e_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    // Reset hold at power-up
    repeat (3) cyc(1'b0, 12'h000, 1'b0, 3'b111, 7'h00, 1'b0);

    start(12'h255, 1'b0, 1'b0);
    scan(1'b0, 3'b110, 7'h6D, 3'b101, 7'h6D, 3'b011, 7'h5B, 1'b0, 2);

    start(12'h007, 1'b1, 1'b0);
    scan(1'b1, 3'b110, 7'h07, 3'b111, 7'h00, 3'b111, 7'h00, 1'b0, 2);

    start(12'h007, 1'b0, 1'b0);
    scan(1'b0, 3'b110, 7'h07, 3'b101, 7'h3F, 3'b011, 7'h3F, 1'b0, 1);

    start(12'h000, 1'b1, 1'b0);
    scan(1'b1, 3'b110, 7'h3F, 3'b111, 7'h00, 3'b111, 7'h00, 1'b0, 1);

    start(12'h100, 1'b1, 1'b0);
    scan(1'b1, 3'b110, 7'h3F, 3'b101, 7'h3F, 3'b011, 7'h06, 1'b0, 1);

    // Invalid tens nibble, then an in-scan reload clears err without a reset.
    start(12'h2A5, 1'b0, 1'b1);
    scan(1'b0, 3'b110, 7'h6D, 3'b101, 7'h40, 3'b011, 7'h5B, 1'b1, 1);
    cyc(1'b1, 12'h100, 1'b0, 3'b101, 7'h40, 1'b0);
    cyc(1'b0, 12'h000, 1'b0, 3'b101, 7'h3F, 1'b0);
    repeat (2) cyc(1'b0, 12'h000, 1'b0, 3'b011, 7'h06, 1'b0);
    repeat (2) cyc(1'b0, 12'h000, 1'b0, 3'b110, 7'h3F, 1'b0);

    // Reset during the tens slot with a load held across the reset edge.
    start(12'h255, 1'b0, 1'b0);
    scan(1'b0, 3'b110, 7'h6D, 3'b101, 7'h6D, 3'b011, 7'h5B, 1'b0, 1);
    cyc(1'b0, 12'h000, 1'b0, 3'b101, 7'h6D, 1'b0);
    reset_now(1'b1, 12'h999);
    cyc(1'b1, 12'h999, 1'b0, 3'b111, 7'h00, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 12'h999, 1'b0, 3'b110, 7'h3F, 1'b0);
    scan(1'b0, 3'b110, 7'h3F, 3'b101, 7'h3F, 3'b011, 7'h3F, 1'b0, 1);

    @(posedge clk);
    #2;
    check("queue_drained", 7'(q.size()), 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
